mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 14 +
 rtl/mem_access_ctrl_mar_reg.sv | 30 +++
 rtl/mem_access_ctrl.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access controller: datapath widths
// and the controller state encoding.
package mem_access_ctrl_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_t;

endpackage

// File: rtl/mem_access_ctrl_mar_reg.sv
// Memory address register (MAR). Loads or increments only while enabled,
// which the controller ties to its idle state so the address stays put
// for the duration of an access. Load wins over increment; the increment
// wraps naturally at the top of the address space.
module mar_reg
    import mem_access_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic              inc,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    // Address register update: load has priority, increment wraps to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            if (load) begin
                q <= d;
            end else if (inc) begin
                q <= q + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: accepts one read/write request at a time,
// strobes memory until mem_ack, then pulses done for one cycle.
// MDR doubles as write-data holder and read-capture register; a separate
// read-data register keeps rdata stable across writes.
// Optional feature macro: MEM_TIMEOUT_EN adds an access timeout of
// TIMEOUT_CYCLES cycles and the sticky timeout_err output.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] mar_in,
    input  logic              mar_load,
    input  logic              mar_inc,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [DATA_W-1:0] wdata,
    output logic              req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
`ifdef MEM_TIMEOUT_EN
    output logic              timeout_err,
`endif
    output logic              done
);

    state_t            state;
    state_t            state_nxt;
    logic              op;
    logic              accept;
    logic              timeout_hit;
    logic [DATA_W-1:0] mdr;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] mar_q;

    // A timeout of less than one cycle has no meaning; nothing is built for it
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_nonpositive
    end

    mar_reg u_mar (
        .clk  (clk),
        .rst  (rst),
        .en   (state == IDLE),
        .load (mar_load),
        .inc  (mar_inc),
        .d    (mar_in),
        .q    (mar_q)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = op;
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operation latch, MDR write-data/read-capture and held read data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op      <= 1'b0;
            mdr     <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                op <= req_write;
                if (req_write) begin
                    mdr <= wdata;
                end
            end
            if ((state == ACCESS) && mem_ack && !op) begin
                mdr     <= mem_rdata;
                rdata_q <= mem_rdata;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    // Count ACCESS cycles; restarts whenever a new request is accepted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (accept) begin
            tmo_cnt <= '0;
        end else if ((state == ACCESS) && (tmo_cnt != CNT_W'(TIMEOUT_CYCLES - 1))) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign timeout_hit = (state == ACCESS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky abort flag, only cleared by reset; a late ack still wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit && !mem_ack) begin
            timeout_err <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    assign mem_addr  = mar_q;
    assign mem_wdata = mdr;
    assign rdata     = rdata_q;

endmodule
